rx_dll_drain: RTL and testbench

Drains the receive-side packet buffer and presents packets to the Data Link Layer over a valid/ready interface, one 256-bit beat per cycle. Sits directly downstream of the RX buffer: pops buffer entries, checks framing consistency (SOP/End_Valid ordering, beat count against Length, Last_Byte against Length), and marks, truncates or drops malformed packets. Keeps a saturating error count for link-health reporting.

---
 rtl/rx_pkg.sv | 32 +++
 rtl/rx_dll_out_stage.sv | 35 +++
 rtl/rx_dll_drain.sv | 178 +++++++++++++++++
 tb/tb_rx_dll_drain.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types, constants and Length-derived framing helpers for the RX drain path.
package rx_pkg;
  localparam int DATA_W  = 256;
  localparam int LEN_W   = 11;
  localparam int LB_W    = 5;
  localparam int CNT_W   = 9;
  localparam int BEAT_DW = 8;
  localparam logic [LB_W-1:0] DLLP_LAST_BYTE = 5'd7;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              typ;
    logic              err;
    logic [LEN_W-1:0]  len;
    logic [LB_W-1:0]   last_byte;
  } beat_t;

  // ceil(len / 8); one extra bit so len=2047 still fits
  function automatic logic [CNT_W-1:0] exp_beats(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] s;
    s = {1'b0, len} + (LEN_W+1)'(BEAT_DW - 1);
    return s[LEN_W:3];
  endfunction

  function automatic logic [LB_W-1:0] exp_last_byte(input logic [LEN_W-1:0] len);
    return {len[2:0] - 3'd1, 2'b11};
  endfunction
endpackage

// File: rtl/rx_dll_out_stage.sv
// One-deep valid/ready output register: loads when told, holds while stalled,
// drops valid once the held beat is consumed and nothing replaces it.
module rx_dll_out_stage
  import rx_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_L,
  input  logic  i_clr,
  input  logic  i_load,
  input  logic  i_Ready,
  input  beat_t i_beat,
  output logic  o_Valid,
  output beat_t o_beat
);
  logic  r_valid;
  beat_t r_beat;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (r_valid && i_Ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_Valid = r_valid;
  assign o_beat  = r_beat;
endmodule

// File: rtl/rx_dll_drain.sv
// Pops the RX buffer, checks SOP/End_Valid/Length framing and forwards, truncates
// or drops beats toward the DLL with one cycle of latency; counts framing errors.
module rx_dll_drain
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH       = 256,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic                        i_Soft_RST,
  input  logic                        i_Empty,
  output logic                        o_RD_EN,
  input  logic [DATA_WIDTH-1:0]       i_Data,
  input  logic                        i_SOP,
  input  logic                        i_End_Valid,
  input  logic                        i_Type,
  input  logic [PACKET_LENGTH-1:0]    i_Length,
  input  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic [DATA_WIDTH-1:0]       o_Data,
  output logic                        o_SOP,
  output logic                        o_EOP,
  output logic                        o_Type,
  output logic                        o_Err,
  output logic [PACKET_LENGTH-1:0]    o_Length,
  output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte,
  output logic [ERR_CNT_WIDTH-1:0]    o_Err_Cnt
);
  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0]        r_exp_n, w_exp_n;
  logic [LB_W-1:0]         r_exp_lb, w_exp_lb;
  logic [LEN_W-1:0]        r_len;
  logic                    r_type;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic                    w_pop, w_load, w_err_evt, w_latch;
  beat_t                   w_beat, w_out;

  assign w_exp_n   = exp_beats(i_Length);
  assign w_exp_lb  = exp_last_byte(i_Length);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_pop     = !i_Empty && (!o_Valid || i_Ready) && !i_Soft_RST;

  always_comb begin
    w_next           = r_state;
    w_cnt_nxt        = r_cnt;
    w_load           = 1'b0;
    w_err_evt        = 1'b0;
    w_latch          = 1'b0;
    w_beat.data      = i_Data;
    w_beat.sop       = 1'b0;
    w_beat.eop       = 1'b0;
    w_beat.typ       = r_type;
    w_beat.err       = 1'b0;
    w_beat.len       = r_len;
    w_beat.last_byte = i_Last_Byte;
    if (w_pop) begin
      case (r_state)
        IDLE: begin
          if (!i_SOP) begin
            w_err_evt = 1'b1;
          end else if (!i_Type) begin
            if (i_End_Valid && i_Last_Byte == DLLP_LAST_BYTE) begin
              w_load     = 1'b1;
              w_beat.sop = 1'b1;
              w_beat.eop = 1'b1;
              w_beat.typ = 1'b0;
              w_beat.len = i_Length;
            end else begin
              w_err_evt = 1'b1;
              if (!i_End_Valid) w_next = DROP;
            end
          end else if (i_Length == '0) begin
            w_err_evt = 1'b1;
            if (!i_End_Valid) w_next = DROP;
          end else begin
            w_latch    = 1'b1;
            w_load     = 1'b1;
            w_beat.sop = 1'b1;
            w_beat.typ = 1'b1;
            w_beat.len = i_Length;
            // A TLP that opens and closes (or must close) on its SOP beat ends here.
            if (i_End_Valid || w_exp_n == 9'd1) begin
              w_beat.eop = 1'b1;
              w_beat.err = !(i_End_Valid && w_exp_n == 9'd1 && i_Last_Byte == w_exp_lb);
              w_err_evt  = w_beat.err;
              w_next     = i_End_Valid ? IDLE : DROP;
            end else begin
              w_cnt_nxt = 9'd1;
              w_next    = IN_PKT;
            end
          end
        end
        IN_PKT: begin
          w_load = 1'b1;
          if (i_SOP) begin
            w_beat.eop = 1'b1;
            w_beat.err = 1'b1;
            w_err_evt  = 1'b1;
            w_next     = i_End_Valid ? IDLE : DROP;
          end else if (i_End_Valid) begin
            w_beat.eop = 1'b1;
            w_beat.err = (w_cnt_inc != r_exp_n) || (i_Last_Byte != r_exp_lb);
            w_err_evt  = w_beat.err;
            w_next     = IDLE;
          end else if (w_cnt_inc == r_exp_n) begin
            w_beat.eop = 1'b1;
            w_beat.err = 1'b1;
            w_err_evt  = 1'b1;
            w_next     = DROP;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        DROP: begin
          if (i_End_Valid) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
      if (w_next != IN_PKT) w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_exp_n   <= '0;
      r_exp_lb  <= '0;
      r_len     <= '0;
      r_type    <= 1'b0;
      r_err_cnt <= '0;
    end else if (i_Soft_RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_exp_n   <= '0;
      r_exp_lb  <= '0;
      r_len     <= '0;
      r_type    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_exp_n  <= w_exp_n;
        r_exp_lb <= w_exp_lb;
        r_len    <= i_Length;
        r_type   <= i_Type;
      end
      if (w_err_evt && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  rx_dll_out_stage u_out (
    .CLK     (CLK),
    .RST_L   (RST_L),
    .i_clr   (i_Soft_RST),
    .i_load  (w_load),
    .i_Ready (i_Ready),
    .i_beat  (w_beat),
    .o_Valid (o_Valid),
    .o_beat  (w_out)
  );

  assign o_RD_EN     = w_pop;
  assign o_Data      = w_out.data;
  assign o_SOP       = w_out.sop;
  assign o_EOP       = w_out.eop;
  assign o_Type      = w_out.typ;
  assign o_Err       = w_out.err;
  assign o_Length    = w_out.len;
  assign o_Last_Byte = w_out.last_byte;
  assign o_Err_Cnt   = r_err_cnt;
endmodule

// File: tb/tb_rx_dll_drain.sv
// Scoreboard bench: a buffer model feeds the DUT, a packet-level reference predicts each forwarded beat.
module tb_rx_dll_drain;
  typedef struct {
    logic [255:0] data;
    logic         sop, ev, typ;
    logic [10:0]  len;
    logic [4:0]   lb;
  } in_beat_t;

  typedef struct {
    logic [255:0] data;
    logic         sop, eop, typ, err;
    logic [10:0]  len;
    logic [4:0]   lb;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_L = 1'b0;
  logic         i_Soft_RST = 1'b0;
  logic         i_Empty = 1'b1;
  logic         o_RD_EN;
  logic [255:0] i_Data = '0;
  logic         i_SOP = 1'b0, i_End_Valid = 1'b0, i_Type = 1'b0;
  logic [10:0]  i_Length = '0;
  logic [4:0]   i_Last_Byte = '0;
  logic         o_Valid;
  logic         i_Ready = 1'b0;
  logic [255:0] o_Data;
  logic         o_SOP, o_EOP, o_Type, o_Err;
  logic [10:0]  o_Length;
  logic [4:0]   o_Last_Byte;
  logic [7:0]   o_Err_Cnt;

  rx_dll_drain dut (
    .CLK(CLK), .RST_L(RST_L), .i_Soft_RST(i_Soft_RST), .i_Empty(i_Empty), .o_RD_EN(o_RD_EN),
    .i_Data(i_Data), .i_SOP(i_SOP), .i_End_Valid(i_End_Valid), .i_Type(i_Type),
    .i_Length(i_Length), .i_Last_Byte(i_Last_Byte), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Data(o_Data), .o_SOP(o_SOP), .o_EOP(o_EOP), .o_Type(o_Type), .o_Err(o_Err),
    .o_Length(o_Length), .o_Last_Byte(o_Last_Byte), .o_Err_Cnt(o_Err_Cnt)
  );

  always #5 CLK = ~CLK;

  in_beat_t bufq[$];
  exp_t     sbq[$];
  int       n_chk = 0, n_fail = 0;
  int       ready_mode = 0;
  logic     s_pop = 1'b0, s_soft = 1'b0;

  // Reference: 0 = between packets, 1 = inside a TLP, 2 = discarding to End_Valid
  int          m_mode = 0, m_need = 0, m_seen = 0, m_errs = 0;
  int          m_lastb = 0;
  logic [10:0] m_len = '0;
  logic        m_typ = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bump_err();
    if (m_errs < 255) m_errs++;
  endtask

  task automatic emit(input in_beat_t b, input logic sop, input logic eop, input logic err,
                      input logic typ, input logic [10:0] len);
    exp_t e;
    e.data = b.data; e.sop = sop; e.eop = eop; e.err = err;
    e.typ = typ; e.len = len; e.lb = b.lb;
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    m_mode = 0; m_seen = 0; m_errs = 0;
  endtask

  task automatic model_beat(input in_beat_t b);
    int need, lastb;
    logic bad;
    need  = (int'(b.len) + 7) / 8;
    lastb = ((b.len % 8 == 0) ? 8 : int'(b.len % 8)) * 4 - 1;
    if (m_mode == 0) begin
      if (!b.sop) bump_err();
      else if (!b.typ) begin
        if (b.ev && b.lb == 5'd7) emit(b, 1, 1, 0, 0, b.len);
        else begin bump_err(); if (!b.ev) m_mode = 2; end
      end else if (b.len == 0) begin
        bump_err(); if (!b.ev) m_mode = 2;
      end else if (b.ev || need == 1) begin
        bad = !(b.ev && need == 1 && int'(b.lb) == lastb);
        emit(b, 1, 1, bad, 1, b.len);
        if (bad) bump_err();
        m_mode = b.ev ? 0 : 2;
      end else begin
        emit(b, 1, 0, 0, 1, b.len);
        m_need = need; m_lastb = lastb; m_len = b.len; m_typ = 1'b1;
        m_seen = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (b.sop) begin
        emit(b, 0, 1, 1, m_typ, m_len); bump_err(); m_mode = b.ev ? 0 : 2;
      end else if (b.ev) begin
        bad = (m_seen + 1 != m_need) || (int'(b.lb) != m_lastb);
        emit(b, 0, 1, bad, m_typ, m_len);
        if (bad) bump_err();
        m_mode = 0;
      end else if (m_seen + 1 == m_need) begin
        emit(b, 0, 1, 1, m_typ, m_len); bump_err(); m_mode = 2;
      end else begin
        emit(b, 0, 0, 0, m_typ, m_len); m_seen++;
      end
    end else begin
      if (b.ev) m_mode = 0;
    end
  endtask

  // Buffer model: presents the head, pops it when the DUT asserted o_RD_EN before the edge
  always @(posedge CLK) begin
    in_beat_t b;
    #1;
    if (s_soft) begin
      sbq.delete();
      model_reset();
    end else if (s_pop && bufq.size() > 0) begin
      b = bufq.pop_front();
      model_beat(b);
    end
    if (bufq.size() > 0) begin
      i_Empty = 1'b0; i_Data = bufq[0].data; i_SOP = bufq[0].sop; i_End_Valid = bufq[0].ev;
      i_Type = bufq[0].typ; i_Length = bufq[0].len; i_Last_Byte = bufq[0].lb;
    end else begin
      i_Empty = 1'b1;
    end
    case (ready_mode)
      0: i_Ready = 1'b1;
      1: i_Ready = ($urandom_range(0, 3) != 0);
      default: i_Ready = ~i_Ready;
    endcase
  end

  // Monitor: checks handshake/pop rule and pops the scoreboard on accepted beats
  always @(negedge CLK) begin
    logic exp_v;
    exp_t e;
    exp_v = (sbq.size() > 0);
    if (RST_L) begin
      chk("o_Valid", o_Valid, exp_v);
      chk("o_RD_EN", o_RD_EN, !i_Empty && (!exp_v || i_Ready) && !i_Soft_RST);
      chk("o_Err_Cnt", o_Err_Cnt, m_errs);
      if (o_Valid && exp_v) begin
        e = sbq[0];
        chk("o_Data", o_Data, e.data);
        chk("o_SOP", o_SOP, e.sop);
        chk("o_EOP", o_EOP, e.eop);
        chk("o_Type", o_Type, e.typ);
        chk("o_Err", o_Err, e.err);
        chk("o_Length", o_Length, e.len);
        if (e.eop && !e.err) chk("o_Last_Byte", o_Last_Byte, e.lb);
        if (i_Ready) void'(sbq.pop_front());
      end
    end
    s_pop  = o_RD_EN;
    s_soft = i_Soft_RST;
  end

  task automatic push(input logic sop, input logic ev, input logic typ,
                      input logic [10:0] len, input logic [4:0] lb);
    in_beat_t b;
    b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.sop = sop; b.ev = ev; b.typ = typ; b.len = len; b.lb = lb;
    bufq.push_back(b);
  endtask

  function automatic logic [4:0] lb_of(input logic [10:0] len);
    int r;
    r = (len % 8 == 0) ? 8 : int'(len % 8);
    return 5'(r * 4 - 1);
  endfunction

  task automatic send_tlp(input logic [10:0] len, input int nbeats, input logic [4:0] lb);
    for (int i = 0; i < nbeats; i++) push(i == 0, i == nbeats - 1, 1'b1, len, lb);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge CLK);
      if (bufq.size() == 0 && sbq.size() == 0 && i_Empty) done = 1;
    end
    repeat (3) @(negedge CLK);
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: bufq=%0d sbq=%0d", bufq.size(), sbq.size());
    end
  endtask

  task automatic soft_reset();
    @(posedge CLK); #2;
    i_Soft_RST = 1'b1;
    bufq.delete();
    @(posedge CLK); #2;
    i_Soft_RST = 1'b0;
    chk("soft_valid", o_Valid, 1'b0);
    chk("soft_sop", o_SOP, 1'b0);
    chk("soft_data", o_Data, '0);
    chk("soft_len", o_Length, '0);
    chk("soft_errcnt", o_Err_Cnt, 8'd0);
  endtask

  initial begin
    int kind, len, n;
    repeat (3) @(posedge CLK);
    chk("rst_valid", o_Valid, 1'b0);
    chk("rst_rd_en", o_RD_EN, 1'b0);
    chk("rst_flags", {o_SOP, o_EOP, o_Type, o_Err}, 4'b0);
    chk("rst_data", o_Data, '0);
    chk("rst_len_lb", {o_Length, o_Last_Byte}, '0);
    chk("rst_errcnt", o_Err_Cnt, 8'd0);
    @(posedge CLK); #2;
    RST_L = 1'b1;

    ready_mode = 0;
    send_tlp(11'd20, 3, 5'd15);
    wait_drain();
    chk("tlp20_errcnt", o_Err_Cnt, 8'd0);

    ready_mode = 2;
    push(1, 1, 0, 11'd5, 5'd7);
    wait_drain();
    chk("dllp_errcnt", o_Err_Cnt, 8'd0);

    ready_mode = 0;
    push(1, 0, 1, 11'd16, 5'd31);
    push(0, 0, 1, 11'd16, 5'd31);
    push(0, 1, 1, 11'd16, 5'd31);
    wait_drain();
    chk("trunc_errcnt", o_Err_Cnt, 8'd1);

    push(1, 0, 1, 11'd24, 5'd31);
    push(0, 0, 1, 11'd24, 5'd31);
    push(1, 0, 1, 11'd24, 5'd31);
    push(0, 0, 1, 11'd24, 5'd31);
    push(0, 1, 1, 11'd24, 5'd31);
    send_tlp(11'd8, 1, 5'd31);
    wait_drain();
    chk("midsop_errcnt", o_Err_Cnt, 8'd2);

    for (int i = 0; i < 300; i++) push(0, i[0], 1, 11'd4, 5'd3);
    wait_drain();
    chk("sat_errcnt", o_Err_Cnt, 8'd255);

    send_tlp(11'd80, 10, 5'd31);
    repeat (5) @(posedge CLK);
    soft_reset();
    send_tlp(11'd13, 2, lb_of(11'd13));
    wait_drain();
    chk("post_soft_errcnt", o_Err_Cnt, 8'd0);

    ready_mode = 1;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 64);
      n    = (len + 7) / 8;
      case (kind)
        6: push(1, 1, 0, 11'($urandom_range(0, 2047)), 5'd7);
        7: push(1, $urandom_range(0, 1), 0, 11'd0, 5'($urandom_range(0, 6)));
        8: send_tlp(11'(len), (n > 1 && $urandom_range(0, 1)) ? n - 1 : n + 1, lb_of(11'(len)));
        9: begin
          if ($urandom_range(0, 1)) push(0, 1, 1, 11'(len), 5'd31);
          else send_tlp(11'(len), n, lb_of(11'(len)) ^ 5'd4);
        end
        default: send_tlp(11'(len), n, lb_of(11'(len)));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
